pdm_pulse_generator: RTL and testbench

- Produces a framed pulse-density bitstream of NUMBER_OF_SAMPLES cycles per frame.
- Each frame carries exactly `code` ones, spread evenly by a first-order error-feedback accumulator.
- It is the generating end of the ones-count decimation path: a loopback stimulus source for the counter, and a 1-bit DAC-style trim/test output for the temperature-sensor front end.
- New codes arrive through a valid/ready handshake and take effect only on frame boundaries.

---
 rtl/pdm_pulse_generator.sv | 125 ++++++++++++
 tb/tb_pdm_pulse_generator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_pulse_generator.sv
// Framed pulse-density bitstream source.
// Each frame is NUMBER_OF_SAMPLES cycles long and carries exactly code_active
// ones, spread evenly by a first-order error-feedback accumulator. New codes
// arrive over a valid/ready handshake into a single pending slot and are only
// picked up at frame boundaries (or at the IDLE->RUN edge).
module pdm_pulse_generator #(
  parameter int NUMBER_OF_SAMPLES = 1650
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [$clog2(NUMBER_OF_SAMPLES+1)-1:0] code_in,
  input  logic                                   code_valid,
  output logic                                   code_ready,
  output logic                                   pulse,
  output logic                                   busy,
  output logic                                   frame_first,
  output logic                                   frame_last
);

  localparam int N      = NUMBER_OF_SAMPLES;
  localparam int IDX_W  = $clog2(N);
  localparam int ACC_W  = IDX_W + 1;
  localparam int CODE_W = $clog2(N + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [CODE_W-1:0] N_CODE   = CODE_W'(N);
  localparam logic [ACC_W-1:0]  N_ACC    = ACC_W'(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Requests above one-per-sample saturate to a solid-ones frame.
  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
    return (c > N_CODE) ? N_CODE : c;
  endfunction

  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [CODE_W-1:0] code_active;
  logic [CODE_W-1:0] pending;
  logic              pending_valid;
  logic              xfer;
  logic              at_last;
  logic              load_pt;

  assign code_ready = !pending_valid;
  assign xfer       = code_valid && code_ready;
  assign at_last    = (idx == LAST_IDX);
  // Codes are swapped either when leaving IDLE or on the last sample edge.
  assign load_pt    = (state == S_IDLE) ? enable : at_last;
  // acc < N and code_active <= N, so the sum stays below 2N and fits ACC_W.
  assign acc_sum    = acc + ACC_W'(code_active);

  // Pending slot and active-code selection; bypass when the slot is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_active   <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (xfer) pending <= clamp_code(code_in);
      if (load_pt) begin
        if (pending_valid) begin
          code_active   <= pending;
          pending_valid <= 1'b0;
        end else if (xfer) begin
          code_active <= clamp_code(code_in);
        end
      end else if (xfer) begin
        pending_valid <= 1'b1;
      end
    end
  end

  // Frame sequencer and error-feedback modulator with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      acc         <= '0;
      pulse       <= 1'b0;
      busy        <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (acc_sum >= N_ACC) begin
            pulse <= 1'b1;
            acc   <= acc_sum - N_ACC;
          end else begin
            pulse <= 1'b0;
            acc   <= acc_sum;
          end
          busy        <= 1'b1;
          frame_first <= (idx == '0);
          frame_last  <= at_last;
          if (at_last) begin
            // Residue is discarded so every frame starts from a clean slate.
            acc   <= '0;
            idx   <= '0;
            state <= enable ? S_RUN : S_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          pulse       <= 1'b0;
          busy        <= 1'b0;
          frame_first <= 1'b0;
          frame_last  <= 1'b0;
          if (enable) begin
            idx   <= '0;
            acc   <= '0;
            state <= S_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_pulse_generator.sv
// Directed bench for pdm_pulse_generator with N = 1650.
module tb_pdm_pulse_generator;

  localparam int NS = 1650;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] code_in;
  logic          code_valid;
  logic          code_ready;
  logic          pulse;
  logic          busy;
  logic          frame_first;
  logic          frame_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic bits [NS];
  logic rdy  [NS];

  pdm_pulse_generator #(.NUMBER_OF_SAMPLES(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .pulse       (pulse),
    .busy        (busy),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a code and hold valid until the edge where it is taken.
  task automatic send_code(input int v, output bit ok);
    ok = 1'b0;
    code_in = CW'(v);
    code_valid = 1'b1;
    for (int k = 0; k < 5000 && !ok; k++) begin
      if (code_ready === 1'b1) ok = 1'b1;
      tick();
    end
    code_valid = 1'b0;
  endtask

  // Find the next frame_first and record one full frame.
  task automatic capture_frame(input int drop_at, input int send_at, input int send_val,
                               output bit found, output int wait_ticks,
                               output int ones, output bit shape_ok);
    found = 1'b0;
    wait_ticks = 0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (frame_first === 1'b1) found = 1'b1;
      else begin
        tick();
        wait_ticks++;
      end
    end
    ones = 0;
    shape_ok = found;
    if (found) begin
      for (int i = 0; i < NS; i++) begin
        bits[i] = pulse;
        rdy[i]  = code_ready;
        if (pulse === 1'b1) ones++;
        if (busy !== 1'b1 || frame_last !== (i == NS - 1) || frame_first !== (i == 0))
          shape_ok = 1'b0;
        if (i == drop_at) enable = 1'b0;
        if (i == send_at) begin
          code_in = CW'(send_val);
          code_valid = 1'b1;
        end
        if (i == send_at + 1) code_valid = 1'b0;
        if (i < NS - 1) tick();
      end
    end
  endtask

  task automatic go_idle;
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    code_valid = 1'b0;
    code_in = '0;
    #1;
    n_tests++;
    if ({pulse, busy, frame_first, frame_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {pulse, busy, frame_first, frame_last});
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (code_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", code_ready);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    bit ok, found, shape;
    int wt, ones, bad;
    send_code(825, ok);
    n_tests++;
    if (!ok || code_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_xfer: ok=%0d code_ready=%b expected ok=1 code_ready=0", ok, code_ready);
    end
    enable = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_edge1: got %b expected 0", busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || frame_first !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_edge2: busy=%b frame_first=%b expected 1 1", busy, frame_first);
    end
    capture_frame(0, -1, 0, found, wt, ones, shape);
    n_tests++;
    if (!found || !shape || ones != 825) begin
      n_fail++;
      $display("FAIL basic_frame: found=%0d shape=%0d ones=%0d expected 1 1 825", found, shape, ones);
    end
    bad = 0;
    for (int i = 0; i < NS; i++)
      if (bits[i] !== ((i % 2) == 1)) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL basic_pattern: %0d samples off the 0,1,0,1 pattern, expected 0", bad);
    end
    go_idle();
  endtask

  task automatic test_edge_codes;
    int codes [3] = '{0, 1, NS};
    bit ok, found, shape;
    int wt, ones;
    for (int c = 0; c < 3; c++) begin
      send_code(codes[c], ok);
      enable = 1'b1;
      capture_frame(0, -1, 0, found, wt, ones, shape);
      n_tests++;
      if (!ok || !found || !shape || ones != codes[c]) begin
        n_fail++;
        $display("FAIL edge_code_%0d: ok=%0d found=%0d shape=%0d ones=%0d expected ones=%0d",
                 codes[c], ok, found, shape, ones, codes[c]);
      end
      if (codes[c] == 1) begin
        n_tests++;
        if (bits[NS-1] !== 1'b1) begin
          n_fail++;
          $display("FAIL edge_code_1_position: last sample=%b expected 1", bits[NS-1]);
        end
      end
      go_idle();
    end
  endtask

  task automatic test_clamp_pending;
    bit ok, found, shape;
    int wt, ones;
    send_code(2000, ok);
    enable = 1'b1;
    capture_frame(-1, 5, 10, found, wt, ones, shape);
    n_tests++;
    if (!ok || !found || ones != NS) begin
      n_fail++;
      $display("FAIL clamp_frame1: ok=%0d found=%0d ones=%0d expected %0d", ok, found, ones, NS);
    end
    n_tests++;
    if (rdy[NS-2] !== 1'b0 || rdy[NS-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_ready_boundary: before=%b at=%b expected 0 1", rdy[NS-2], rdy[NS-1]);
    end
    capture_frame(0, -1, 0, found, wt, ones, shape);
    n_tests++;
    if (!found || !shape || wt != 1 || ones != 10) begin
      n_fail++;
      $display("FAIL clamp_frame2: found=%0d shape=%0d gap=%0d ones=%0d expected 1 1 1 10",
               found, shape, wt, ones);
    end
    go_idle();
  endtask

  task automatic test_bypass;
    bit ok, found, shape;
    int wt, ones;
    send_code(100, ok);
    enable = 1'b1;
    capture_frame(-1, NS - 2, 300, found, wt, ones, shape);
    n_tests++;
    if (!ok || !found || !shape || ones != 100) begin
      n_fail++;
      $display("FAIL bypass_frameA: ok=%0d found=%0d shape=%0d ones=%0d expected 100", ok, found, shape, ones);
    end
    n_tests++;
    if (rdy[NS-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_ready: got %b expected 1", rdy[NS-1]);
    end
    capture_frame(0, -1, 0, found, wt, ones, shape);
    n_tests++;
    if (!found || wt != 1 || ones != 300) begin
      n_fail++;
      $display("FAIL bypass_frameB: found=%0d gap=%0d ones=%0d expected 1 1 300", found, wt, ones);
    end
    go_idle();
  endtask

  task automatic test_enable_drop;
    bit ok, found, shape, stray;
    int wt, ones;
    send_code(500, ok);
    enable = 1'b1;
    capture_frame(400, -1, 0, found, wt, ones, shape);
    n_tests++;
    if (!ok || !found || !shape || ones != 500) begin
      n_fail++;
      $display("FAIL drop_frame: ok=%0d found=%0d shape=%0d ones=%0d expected 1 1 1 500", ok, found, shape, ones);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_busy_fall: got %b expected 0", busy);
    end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL drop_quiet: activity after frame got 1 expected 0");
    end
  endtask

  task automatic test_async_reset;
    bit ok, found, shape;
    int wt, ones;
    send_code(700, ok);
    enable = 1'b1;
    repeat (60) tick();
    send_code(900, ok);
    n_tests++;
    if (!ok || code_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_setup: ok=%0d code_ready=%b busy=%b expected 1 0 1", ok, code_ready, busy);
    end
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({pulse, busy, frame_first, frame_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_outputs: got %b expected 0000", {pulse, busy, frame_first, frame_last});
    end
    n_tests++;
    if (code_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_ready: got %b expected 1", code_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    capture_frame(0, -1, 0, found, wt, ones, shape);
    n_tests++;
    if (!found || !shape || ones != 0) begin
      n_fail++;
      $display("FAIL areset_code0: found=%0d shape=%0d ones=%0d expected 1 1 0", found, shape, ones);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_codes();
    test_clamp_pending();
    test_bypass();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
